// File: rtl/wave_pkg.sv
// wave_pkg: shared types and constants for the wave averager, plus the row
// mapping function. Build option WAVE_AVERAGER_CLIP_EN selects clamping of the
// row coordinate to the visible range instead of modulo-512 wrap.
package wave_pkg;

   localparam int WIDTH = 24;   // sample width, signed two's complement
   localparam int DIV   = 15;   // right shift applied to the mean for row mapping
   localparam int Y_MID = 240;  // row of zero amplitude
   localparam int Y_MAX = 479;  // last visible row

   typedef logic signed [WIDTH-1:0] sample_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

   // Map a block mean to a VGA row; positive amplitude moves up the screen.
   function automatic logic [8:0] row_map(input sample_t mean);
      logic signed [WIDTH:0] mean_ext;
      logic signed [WIDTH:0] yraw;
      mean_ext = (WIDTH+1)'(mean);
      yraw     = (WIDTH+1)'(Y_MID) - (mean_ext >>> DIV);
`ifdef WAVE_AVERAGER_CLIP_EN
      if (yraw < 0) begin
         row_map = '0;
      end else if (yraw > Y_MAX) begin
         row_map = 9'(Y_MAX);
      end else begin
         row_map = 9'(yraw);
      end
`else
      // Plain modulo-512 wrap: out-of-range rows alias back onto the screen.
      row_map = 9'(yraw);
`endif
   endfunction

endpackage

// File: rtl/wave_accumulator.sv
// wave_accumulator: sums blocks of 2^LOG_N signed samples. done pulses
// combinationally on the strobe that carries the last sample of a block, with
// mean holding the floored block mean for that same cycle.
module wave_accumulator
   import wave_pkg::*;
#(
   parameter int LOG_N = 11
) (
   input  logic    clk,
   input  logic    reset_n,
   input  logic    clear,
   input  logic    sample_valid,
   input  sample_t sample,
   output logic    done,
   output sample_t mean
);

   localparam int AW = WIDTH + LOG_N;

   logic signed [AW-1:0] acc_q, acc_d, total;
   logic [LOG_N-1:0]     count_q, count_d;

   // Running sum, block completion detect and next-state selection.
   always_comb begin
      total   = acc_q + AW'(sample);
      done    = sample_valid & ~clear & (&count_q);
      // Arithmetic shift floors toward -inf; the shifted value always fits WIDTH.
      mean    = WIDTH'(total >>> LOG_N);
      acc_d   = acc_q;
      count_d = count_q;
      if (clear) begin
         acc_d   = '0;
         count_d = '0;
      end else if (sample_valid) begin
         if (done) begin
            acc_d   = '0;
            count_d = '0;
         end else begin
            acc_d   = total;
            count_d = count_q + 1'b1;
         end
      end
   end

   // Accumulator and sample counter state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q   <= '0;
         count_q <= '0;
      end else begin
         acc_q   <= acc_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/wave_averager.sv
// wave_averager: block-averages codec samples and presents mean plus row
// coordinate through a one-entry valid/ready register. A completed block that
// finds the register occupied and not draining is dropped and flags overrun.
// Build option WAVE_AVERAGER_CLIP_EN clamps the row to 0..Y_MAX.
module wave_averager
   import wave_pkg::*;
#(
   parameter int LOG_N = 11
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       sample_valid,
   input  sample_t    sample,
   output logic       out_valid,
   input  logic       out_ready,
   output sample_t    avg_sample,
   output logic [8:0] y,
   output logic       overrun
);

   logic       blk_done;
   sample_t    blk_mean;

   out_state_e state_q;
   sample_t    avg_q;
   logic [8:0] y_q;
   logic       overrun_q;

   wave_accumulator #(
      .LOG_N(LOG_N)
   ) u_acc (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear       (clear),
      .sample_valid(sample_valid),
      .sample      (sample),
      .done        (blk_done),
      .mean        (blk_mean)
   );

   // Output register FSM: load on completion, drain on handshake, flag drops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= EMPTY;
         avg_q     <= '0;
         y_q       <= 9'(Y_MID);
         overrun_q <= 1'b0;
      end else if (clear) begin
         state_q   <= EMPTY;
         overrun_q <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (blk_done) begin
                  state_q <= FULL;
                  avg_q   <= blk_mean;
                  y_q     <= row_map(blk_mean);
               end
            end
            FULL: begin
               if (blk_done && out_ready) begin
                  // Old result leaves as the new one arrives.
                  avg_q <= blk_mean;
                  y_q   <= row_map(blk_mean);
               end else if (blk_done) begin
                  // Consumer still holds the old result: keep it, drop the new one.
                  overrun_q <= 1'b1;
               end else if (out_ready) begin
                  state_q <= EMPTY;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

   assign out_valid  = (state_q == FULL);
   assign avg_sample = avg_q;
   assign y          = y_q;
   assign overrun    = overrun_q;

endmodule
